decoder_scan: RTL
=================

DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter SEL_W, default 2: select width; output width N = 2**SEL_W.
REQ-002 Parameter DWELL_W, default 4: width of the scan dwell count.
REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  block enable; 0 forces outputs inactive.
REQ-006 mode  input  1  0 = DIRECT decode, 1 = SCAN (auto-advancing one-hot).
REQ-007 sel  input  SEL_W  decode index (DIRECT) or scan start index (SCAN entry).
REQ-008 dwell  input  DWELL_W  cycles-minus-one each index is held in SCAN.
REQ-009 out  output  N  registered one-hot decode; bit k high means index k active.
REQ-010 idx  output  SEL_W  registered index currently driven on out.
REQ-011 wrap  output  1  one-cycle pulse when SCAN index wraps from N-1 to 0.

Function
REQ-012 FSM states SHALL be IDLE, DIRECT, SCAN; state, out, idx, wrap all registered.
REQ-013 Next state SHALL be IDLE when en=0, DIRECT when en=1 and mode=0, SCAN when en=1 and mode=1.
REQ-014 In IDLE, out SHALL be all zeros, idx SHALL hold its last value, wrap SHALL be 0, dwell counter SHALL be 0.
REQ-015 DIRECT: out SHALL equal one-hot(sel) and idx SHALL equal sel one cycle after sel is sampled (latency 1), tracking sel every cycle.
REQ-016 SCAN entry (transition from IDLE or DIRECT): idx SHALL load sel, dwell counter SHALL load dwell, out SHALL be one-hot(sel) on the next cycle.
REQ-017 In SCAN, dwell counter SHALL decrement each cycle; when it is 0, idx SHALL increment modulo N and the counter SHALL reload the current dwell input.
REQ-018 Each index SHALL therefore be held dwell+1 cycles; dwell=0 SHALL advance every cycle; dwell=all-ones SHALL hold 2**DWELL_W cycles.
REQ-019 wrap SHALL be 1 for exactly the cycle in which idx shows 0 after advancing from N-1; never asserted on SCAN entry, even when sel=0.
REQ-020 out SHALL be exactly one-hot in DIRECT and SCAN, all-zero in IDLE; no other pattern is permitted.
REQ-021 Changes to sel while in SCAN SHALL be ignored; changes to dwell take effect at the next reload.
REQ-022 mode toggle while en=1 SHALL switch behaviour on the next edge; SCAN re-entry SHALL always restart from sel.
REQ-023 en deassertion mid-scan SHALL zero out on the next edge; re-enable SHALL re-enter per REQ-016.

Reset
REQ-024 On rst=1, regardless of clk: state=IDLE, out=0, idx=0, wrap=0, dwell counter=0.
REQ-025 After rst release, first active output SHALL appear one edge after en=1 is sampled.

Structure
REQ-026 State encodings (IDLE/DIRECT/SCAN) and mode constants SHALL live in shared include decoder_defs.v.
REQ-027 One combinational sub-module onehot_dec (parameter SEL_W, index in, N-bit one-hot out) SHALL perform the decode; decoder_scan instantiates it once.
REQ-028 Expected RTL size 120-250 lines including onehot_dec.

Verification (SEL_W=2, DWELL_W=4)
REQ-029 rst pulse mid-cycle with en=1, mode=1 -> out=0000, idx=0, wrap=0 immediately, without a clock edge.
REQ-030 en=1, mode=0, sel=0,1,2,3 one per cycle -> out=0001,0010,0100,1000, each one cycle after its sel.
REQ-031 en=1, mode=1, sel=2, dwell=1 -> out 0100 x2, 1000 x2, 0001 x2 (wrap=1 on first 0001 cycle only), 0010 x2.
REQ-032 mode=1, dwell=0, sel=0 -> out rotates 0001,0010,0100,1000 every cycle; wrap pulses every 4th cycle; no wrap on entry.
REQ-033 SCAN at idx=3, en dropped for 1 cycle then restored with sel=1 -> out 0000 for one cycle, then 0010 with counter reloaded.
REQ-034 SCAN with dwell=3, dwell changed to 0 mid-hold -> current index completes 4 cycles, subsequent indices advance every cycle.

Source files
------------

// File: rtl/decoder_scan_pkg.sv
// Shared state encodings, mode constants and next-state rule for decoder_scan.
package decoder_scan_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic [1:0] next_state(input logic en, input logic mode);
    logic [1:0] ns;
    ns = ST_IDLE;
    if (en) begin
      case (mode)
        MODE_DIRECT: ns = ST_DIRECT;
        MODE_SCAN:   ns = ST_SCAN;
        default:     ns = ST_IDLE;
      endcase
    end
    return ns;
  endfunction

endpackage

// File: rtl/decoder_scan_onehot_dec.sv
// Combinational binary-to-one-hot decoder; zero latency, no flow control.
module onehot_dec #(
  parameter int SEL_W = 2
) (
  input  logic [SEL_W-1:0]    index,
  output logic [2**SEL_W-1:0] onehot
);

  always_comb begin
    onehot        = '0;
    onehot[index] = 1'b1;
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered one-hot decoder with DIRECT decode and auto-advancing SCAN mode.
// All outputs are registered (latency 1 from sampled inputs); no backpressure.
module decoder_scan
  import decoder_scan_pkg::*;
#(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode,
  input  logic [SEL_W-1:0]    sel,
  input  logic [DWELL_W-1:0]  dwell,
  output logic [2**SEL_W-1:0] out,
  output logic [SEL_W-1:0]    idx,
  output logic                wrap
);

  localparam int N = 2**SEL_W;

  logic [1:0]         state;
  logic [1:0]         state_nxt;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] cnt_nxt;
  logic [SEL_W-1:0]   idx_nxt;
  logic               wrap_nxt;
  logic [N-1:0]       dec;

  always_comb begin
    state_nxt = next_state(en, mode);
    idx_nxt   = idx;
    cnt_nxt   = '0;
    wrap_nxt  = 1'b0;
    case (state_nxt)
      ST_DIRECT: idx_nxt = sel;
      ST_SCAN: begin
        // Any entry into SCAN restarts from sel, so wrap can never fire on entry.
        if (state != ST_SCAN) begin
          idx_nxt = sel;
          cnt_nxt = dwell;
        end else if (cnt == '0) begin
          idx_nxt  = idx + 1'b1;
          cnt_nxt  = dwell;
          wrap_nxt = (idx == {SEL_W{1'b1}});
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: ;
    endcase
  end

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .index  (idx_nxt),
    .onehot (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      idx   <= '0;
      wrap  <= 1'b0;
      out   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      wrap  <= wrap_nxt;
      out   <= (state_nxt == ST_IDLE) ? '0 : dec;
    end
  end

endmodule
